// File: rtl/gpu_pixel_writer_pkg.sv
// Shared types and helpers for the pixel writer and raster counter.
package gpu_pixel_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PIX,
    WRITE,
    DONE
  } pixel_writer_state_e;

  localparam logic [31:0] DEFAULT_BUFFER = 32'hC800_0000;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpu_raster_counter.sv
// Raster-order x/y position with last-pixel flag and byte offset.
module gpu_raster_counter
  import gpu_pixel_writer_pkg::*;
#(
  parameter int H_RESOLUTION = 256,
  parameter int V_RESOLUTION = 192,
  parameter int BYTES        = 2,
  parameter int ROW_STRIDE   = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        advance,
  output logic        last_pixel,
  output logic [31:0] offset
);

  localparam int XW = (log2c(H_RESOLUTION) < 1) ? 1 : log2c(H_RESOLUTION);
  localparam int YW = (log2c(V_RESOLUTION) < 1) ? 1 : log2c(V_RESOLUTION);
  localparam int Y_SH = log2c(ROW_STRIDE);
  localparam int X_SH = log2c(BYTES);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last;

  assign x_last = (x_q == XW'(H_RESOLUTION - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign last_pixel = x_last && (y_q == YW'(V_RESOLUTION - 1));
  assign offset = (32'(y_q) << Y_SH) + (32'(x_q) << X_SH);

endmodule

// File: rtl/gpu_pixel_writer.sv
// Avalon-MM initiator writing a raster pixel stream byte by byte.
// Optional abort input enabled by GPU_PIXEL_WRITER_ABORT_EN.
module gpu_pixel_writer
  import gpu_pixel_writer_pkg::*;
#(
  parameter int H_RESOLUTION = 256,
  parameter int V_RESOLUTION = 192,
  parameter int PIXEL_BITS   = 16,
  parameter int ROW_STRIDE   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           base_address,
  input  logic                  pixel_valid,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  pixel_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           m1_address,
  output logic [7:0]            m1_writedata,
  output logic                  m1_write,
`ifdef GPU_PIXEL_WRITER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  m1_waitrequest
);

  localparam int BYTES = PIXEL_BITS / 8;
  localparam int BW = (log2c(BYTES) < 1) ? 1 : log2c(BYTES);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

  pixel_writer_state_e   state_q, state_d;
  logic [31:0]           base_q, base_d;
  logic [PIXEL_BITS-1:0] pixel_q, pixel_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic                  clear, advance, last_pixel;
  logic [31:0]           offset;
`ifdef GPU_PIXEL_WRITER_ABORT_EN
  logic                  abort_q, abort_d;
`endif

  gpu_raster_counter #(
    .H_RESOLUTION(H_RESOLUTION),
    .V_RESOLUTION(V_RESOLUTION),
    .BYTES       (BYTES),
    .ROW_STRIDE  (ROW_STRIDE)
  ) u_raster (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .advance   (advance),
    .last_pixel(last_pixel),
    .offset    (offset)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    pixel_d = pixel_q;
    byte_d  = byte_q;
    clear   = 1'b0;
    advance = 1'b0;
`ifdef GPU_PIXEL_WRITER_ABORT_EN
    abort_d = abort_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_address;
          clear   = 1'b1;
          state_d = WAIT_PIX;
        end
      end
      WAIT_PIX: begin
`ifdef GPU_PIXEL_WRITER_ABORT_EN
        if (abort) begin
          state_d = IDLE;
        end else
`endif
        if (pixel_valid) begin
          pixel_d = pixel_data;
          byte_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef GPU_PIXEL_WRITER_ABORT_EN
        // A stalled abort is remembered until the byte in flight lands.
        if (abort) abort_d = 1'b1;
        if (!m1_waitrequest && (abort || abort_q)) begin
          abort_d = 1'b0;
          state_d = IDLE;
        end else
`endif
        if (!m1_waitrequest) begin
          if (byte_q != BYTE_LAST) begin
            byte_d = byte_q + BW'(1);
          end else if (last_pixel) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = WAIT_PIX;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      pixel_q <= '0;
      byte_q  <= '0;
`ifdef GPU_PIXEL_WRITER_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pixel_q <= pixel_d;
      byte_q  <= byte_d;
`ifdef GPU_PIXEL_WRITER_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

`ifdef GPU_PIXEL_WRITER_ABORT_EN
  assign pixel_ready = (state_q == WAIT_PIX) && !abort;
`else
  assign pixel_ready = (state_q == WAIT_PIX);
`endif
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign m1_write   = (state_q == WRITE);

  always_comb begin
    m1_address   = '0;
    m1_writedata = '0;
    if (m1_write) begin
      m1_address   = base_q + offset + 32'(byte_q);
      m1_writedata = 8'(pixel_q >> (8 * byte_q));
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed scoreboard bench for gpu_pixel_writer (H=4, V=2, 16-bit pixels).
module tb_gpu_pixel_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int PB = 16;
  localparam int BY = PB / 8;
  localparam int RS = 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_address = '0;
  logic          pixel_valid = 1'b0;
  logic [PB-1:0] pixel_data = '0;
  logic          m1_waitrequest = 1'b0;
  logic          abort = 1'b0;
  logic          pixel_ready, busy, frame_done, m1_write;
  logic [31:0]   m1_address;
  logic [7:0]    m1_writedata;

  gpu_pixel_writer #(
    .H_RESOLUTION(H),
    .V_RESOLUTION(V),
    .PIXEL_BITS  (PB),
    .ROW_STRIDE  (RS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .base_address  (base_address),
    .pixel_valid   (pixel_valid),
    .pixel_data    (pixel_data),
    .pixel_ready   (pixel_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .m1_address    (m1_address),
    .m1_writedata  (m1_writedata),
    .m1_write      (m1_write),
`ifdef GPU_PIXEL_WRITER_ABORT_EN
    .abort         (abort),
`endif
    .m1_waitrequest(m1_waitrequest)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t exp_q[$];

  int          writes = 0;
  int          frames = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] last_a = '0;
  logic [7:0]  last_d = '0;
  int          mx, my;
  logic [31:0] mbase;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (frame_done) begin
      frames++;
      done_cyc = cyc;
    end
    if (m1_write && !m1_waitrequest) begin
      wr_t e;
      writes++;
      last_wr_cyc = cyc;
      last_a = m1_address;
      last_d = m1_writedata;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", m1_address, e.a);
        check("wr_data", 32'(m1_writedata), 32'(e.d));
      end
    end
  end

  task automatic start_frame(input logic [31:0] b);
    @(posedge clock); #1;
    base_address = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    mx = 0;
    my = 0;
    mbase = b;
  endtask

  task automatic send_pixel(input logic [PB-1:0] d, output int acc);
    bit got;
    got = 0;
    acc = -1;
    pixel_valid = 1'b1;
    pixel_data = d;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      if (pixel_ready) begin
        for (int b = 0; b < BY; b++) begin
          exp_q.push_back('{a: mbase + 32'(my * RS + mx * BY + b),
                            d: 8'(d >> (8 * b))});
        end
        if (mx == H - 1) begin
          mx = 0;
          my++;
        end else begin
          mx++;
        end
        @(posedge clock); #1;
        acc = cyc;
        pixel_valid = 1'b0;
        got = 1;
      end
    end
    check("pix_accept", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input int f0);
    bit seen;
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(posedge clock); #1;
      if (frames > f0) seen = 1;
    end
    check("frame_done_seen", 32'(frames - f0), 32'd1);
    check("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc0, acc1, acc, f0, w0;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_write", 32'(m1_write), 32'd0);
    check("rst_ready", 32'(pixel_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_addr", m1_address, 32'd0);
    check("rst_data", 32'(m1_writedata), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Test 1: full frame, no stalls
    f0 = frames;
    w0 = writes;
    start_frame(32'hC800_0000);
    check("t1_busy", 32'(busy), 32'd1);
    send_pixel(16'h0101, acc0);
    send_pixel(16'h0202, acc1);
    check("t1_throughput", 32'(acc1 - acc0), 32'(BY + 1));
    for (int i = 2; i < 7; i++) send_pixel(16'(i * 16'h1111), acc);
    send_pixel(16'hBEEF, acc);
    wait_done(f0);
    check("t1_writes", 32'(writes - w0), 32'd16);
    check("t1_last_addr", last_a, 32'hC800_0407);
    check("t1_last_data", 32'(last_d), 32'hBE);
    check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Test 2: 5-cycle stall on byte 1 of pixel 0
    f0 = frames;
    start_frame(32'h1000_0000);
    send_pixel(16'h1234, acc);
    @(posedge clock); #1;
    m1_waitrequest = 1'b1;
    w0 = writes;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t2_hold_addr", m1_address, 32'h1000_0001);
      check("t2_hold_data", 32'(m1_writedata), 32'h12);
      check("t2_hold_write", 32'(m1_write), 32'd1);
      check("t2_hold_ready", 32'(pixel_ready), 32'd0);
    end
    @(posedge clock); #1;
    m1_waitrequest = 1'b0;
    @(posedge clock); #1;
    check("t2_one_write", 32'(writes - w0), 32'd1);
    for (int i = 1; i < 8; i++) send_pixel(16'(16'h3000 + i), acc);
    wait_done(f0);

    // Test 3: reset during WRITE of pixel 3
    start_frame(32'h2000_0000);
    for (int i = 0; i < 4; i++) send_pixel(16'(16'h4000 + i), acc);
    #1 reset = 1'b1;
    #1;
    check("t3_write_drop", 32'(m1_write), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_ready", 32'(pixel_ready), 32'd0);
    check("t3_addr", m1_address, 32'd0);
    check("t3_data", 32'(m1_writedata), 32'd0);
    exp_q.delete();
    f0 = frames;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    check("t3_start_in_reset", 32'(busy), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("t3_no_done", 32'(frames - f0), 32'd0);

    // Restart, then Test 4: ignored mid-frame start
    start_frame(32'hC800_0000);
    send_pixel(16'hAAAA, acc);
    check("t3_restart_addr", m1_address, 32'hC800_0000);
    send_pixel(16'hAAAB, acc);
    send_pixel(16'hAAAC, acc);
    base_address = 32'h0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 3; i < 8; i++) send_pixel(16'(16'h5000 + i), acc);
    wait_done(f0);

    // Test 5: valid held in IDLE, gapped stream
    pixel_valid = 1'b1;
    pixel_data = 16'hA5A5;
    w0 = writes;
    repeat (3) @(posedge clock);
    #1;
    check("t5_idle_ready", 32'(pixel_ready), 32'd0);
    check("t5_idle_nowrite", 32'(writes - w0), 32'd0);
    f0 = frames;
    start_frame(32'h0000_1000);
    send_pixel(16'hA5A5, acc);
    for (int i = 1; i < 8; i++) begin
      repeat (i % 3) @(posedge clock);
      send_pixel(16'(16'h6000 + i * 3), acc);
    end
    wait_done(f0);
    check("t5_writes", 32'(writes - w0), 32'd16);

`ifdef GPU_PIXEL_WRITER_ABORT_EN
    // Test 6: abort while stalled in WRITE
    f0 = frames;
    start_frame(32'h3000_0000);
    m1_waitrequest = 1'b1;
    send_pixel(16'h7777, acc);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("t6_busy_stall", 32'(busy), 32'd1);
    check("t6_write_stall", 32'(m1_write), 32'd1);
    w0 = writes;
    m1_waitrequest = 1'b0;
    @(posedge clock); #1;
    check("t6_one_write", 32'(writes - w0), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_write", 32'(m1_write), 32'd0);
    check("t6_leftover", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    check("t6_no_done", 32'(frames - f0), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
